// File: rtl/dostring_pkg.sv
// dostring_pkg: framing constants and receiver states shared by dostring_rx and dostring_wave
package dostring_pkg;
  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;
  localparam logic [2:0] PIX_HDR = 3'b111;
  typedef enum logic {HUNT, PIXEL} state_t;
endpackage

// File: rtl/dostring_sync.sv
// dostring_sync: synchronizes sck/mosi into clk and flags sck rising edges
module dostring_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic mosi,
  output logic sck_rise,
  output logic mosi_s
);
  logic [SYNC_STAGES:0] sck_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  always_ff @(posedge clk)
    if (rst) begin
      sck_q <= '0;
      mosi_q <= '0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-1:0], sck};
      mosi_q <= SYNC_STAGES'({mosi_q, mosi});
    end
  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_q[SYNC_STAGES];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/dostring_rx.sv
// dostring_rx: receives LED start/pixel/end frames from an sck/mosi link and emits pixel and frame strobes
module dostring_rx
  import dostring_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic             dostring_clk,
  input  logic             my_reset,
  input  logic             sck,
  input  logic             mosi,
  output logic             pix_valid,
  output logic [4:0]       pix_bright,
  output logic [7:0]       pix_blue,
  output logic [7:0]       pix_green,
  output logic [7:0]       pix_red,
  output logic [IDX_W-1:0] pix_index,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [IDX_W-1:0] led_count
);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic sck_rise, mosi_s;
  state_t state, state_nxt;
  logic [30:0] sreg;
  logic [31:0] word;
  logic [4:0] bit_cnt;
  logic [TW-1:0] idle_cnt;
  logic [IDX_W-1:0] pix_cnt;
  logic word_full, timeout, start_nxt, done_nxt, err_nxt, pix_nxt;

  dostring_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(dostring_clk),
    .rst(my_reset),
    .sck(sck),
    .mosi(mosi),
    .sck_rise(sck_rise),
    .mosi_s(mosi_s)
  );

  // In HUNT bit_cnt counts the zero run; in PIXEL it counts bits of the current word.
  always_comb begin
    word = {sreg, mosi_s};
    word_full = sck_rise && bit_cnt == 5'd31;
    timeout = state == PIXEL && !sck_rise && idle_cnt == TW'(IDLE_TIMEOUT - 1);
    state_nxt = state;
    start_nxt = 1'b0;
    done_nxt = 1'b0;
    err_nxt = 1'b0;
    pix_nxt = 1'b0;
    if (state == HUNT) begin
      if (word_full && !mosi_s) begin
        start_nxt = 1'b1;
        state_nxt = PIXEL;
      end
    end else if (timeout) begin
      done_nxt = bit_cnt == 5'd0 && pix_cnt != '0;
      err_nxt = !done_nxt;
      state_nxt = HUNT;
    end else if (word_full) begin
      if (word == START_WORD) start_nxt = 1'b1;
      else if (word == END_WORD) begin
        done_nxt = 1'b1;
        state_nxt = HUNT;
      end else if (word[31:29] == PIX_HDR && pix_cnt != '1) pix_nxt = 1'b1;
      else begin
        err_nxt = 1'b1;
        state_nxt = HUNT;
      end
    end
  end

  always_ff @(posedge dostring_clk)
    if (my_reset) begin
      state <= HUNT;
      sreg <= '0;
      bit_cnt <= '0;
      idle_cnt <= '0;
      pix_cnt <= '0;
      {pix_valid, frame_start, frame_done, frame_err} <= '0;
      {pix_bright, pix_blue, pix_green, pix_red} <= '0;
      pix_index <= '0;
      led_count <= '0;
    end else begin
      state <= state_nxt;
      {pix_valid, frame_start, frame_done, frame_err} <= {pix_nxt, start_nxt, done_nxt, err_nxt};
      if (sck_rise) sreg <= word[30:0];
      bit_cnt <= state_nxt != state ? '0 : !sck_rise ? bit_cnt :
                 (state == HUNT && mosi_s) ? '0 : bit_cnt + 5'd1;
      idle_cnt <= (state == PIXEL && state_nxt == PIXEL && !sck_rise) ? idle_cnt + 1'b1 : '0;
      pix_cnt <= start_nxt ? '0 : pix_nxt ? pix_cnt + 1'b1 : pix_cnt;
      pix_index <= start_nxt ? '0 : pix_nxt ? pix_cnt : pix_index;
      if (pix_nxt) {pix_bright, pix_blue, pix_green, pix_red} <= word[28:0];
      if (done_nxt) led_count <= pix_cnt;
    end
endmodule

// File: tb/tb_dostring_rx.sv
// tb_dostring_rx: random and directed frames checked against a bit-stream reference model
module tb_dostring_rx;
  localparam int IDX_W = 3;
  localparam int IDLE = 4096;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic pix_valid, frame_start, frame_done, frame_err;
  logic [4:0] pix_bright;
  logic [7:0] pix_blue, pix_green, pix_red;
  logic [IDX_W-1:0] pix_index, led_count;
  int total = 0, bad = 0;
  logic [51:0] got_q[$], exp_q[$];
  bit bits[$];
  logic [IDX_W-1:0] m_led = '0;
  logic [31:0] m_last = '0;
  bit m_busy;

  always #5 clk = ~clk;

  dostring_rx #(.IDX_W(IDX_W), .IDLE_TIMEOUT(IDLE), .SYNC_STAGES(SYNC)) dut (
    .dostring_clk(clk),
    .my_reset(rst),
    .sck(sck),
    .mosi(mosi),
    .pix_valid(pix_valid),
    .pix_bright(pix_bright),
    .pix_blue(pix_blue),
    .pix_green(pix_green),
    .pix_red(pix_red),
    .pix_index(pix_index),
    .frame_start(frame_start),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .led_count(led_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // event = {kind, value, data}: 1 start, 2 pixel (value=index), 3 done, 4 err (value=led_count)
  function automatic logic [51:0] ev(input logic [3:0] k, input logic [IDX_W-1:0] v, input logic [31:0] d);
    return {k, 16'(v), d};
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst)
      check("rst_zero", {pix_valid, frame_start, frame_done, frame_err, pix_index, led_count,
                         pix_bright, pix_blue, pix_green, pix_red}, 64'd0);
    else if (pix_valid | frame_start | frame_done | frame_err) begin
      check("onehot", 64'($countones({pix_valid, frame_start, frame_done, frame_err})), 64'd1);
      if (frame_start) got_q.push_back(ev(4'd1, led_count, 32'd0));
      if (pix_valid) got_q.push_back(ev(4'd2, pix_index, {3'b111, pix_bright, pix_blue, pix_green, pix_red}));
      if (frame_done) got_q.push_back(ev(4'd3, led_count, 32'd0));
      if (frame_err) got_q.push_back(ev(4'd4, led_count, 32'd0));
    end
  end

  task automatic model(input bit allow_idle);
    int zeros = 0, n = 0, cnt = 0;
    bit fr = 0;
    logic [31:0] w = '0;
    foreach (bits[i]) begin
      if (!fr) begin
        zeros = bits[i] ? 0 : zeros + 1;
        if (zeros == 32) begin
          exp_q.push_back(ev(4'd1, m_led, 32'd0));
          fr = 1; zeros = 0; n = 0; cnt = 0;
        end
      end else begin
        w = {w[30:0], bits[i]};
        n++;
        if (n == 32) begin
          n = 0;
          if (w == 32'h0) begin
            exp_q.push_back(ev(4'd1, m_led, 32'd0));
            cnt = 0;
          end else if (w == 32'hFFFF_FFFF) begin
            m_led = IDX_W'(cnt);
            exp_q.push_back(ev(4'd3, m_led, 32'd0));
            fr = 0;
          end else if (w[31:29] == 3'b111 && cnt < (1 << IDX_W) - 1) begin
            exp_q.push_back(ev(4'd2, IDX_W'(cnt), w));
            m_last = w;
            cnt++;
          end else begin
            exp_q.push_back(ev(4'd4, m_led, 32'd0));
            fr = 0;
          end
        end
      end
    end
    m_busy = fr;
    if (fr && allow_idle) begin
      if (n == 0 && cnt > 0) begin
        m_led = IDX_W'(cnt);
        exp_q.push_back(ev(4'd3, m_led, 32'd0));
      end else exp_q.push_back(ev(4'd4, m_led, 32'd0));
    end
  endtask

  task automatic add(input logic [31:0] w, input int n = 32);
    for (int i = n - 1; i >= 0; i--) bits.push_back(w[i]);
  endtask

  function automatic logic [31:0] rnd_pix();
    return {3'b111, 29'($urandom)};
  endfunction

  task automatic send_bit(input bit b);
    mosi = b;
    repeat ($urandom_range(3, 4)) @(negedge clk);
    sck = 1'b1;
    repeat ($urandom_range(3, 4)) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic run(input string name, input bit allow_idle);
    model(allow_idle);
    foreach (bits[i]) send_bit(bits[i]);
    repeat ((allow_idle && m_busy) ? IDLE + 30 : 30) @(negedge clk);
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) check(name, i < got_q.size() ? 64'(got_q[i]) : '1, 64'(exp_q[i]));
    check({name, "_led"}, 64'(led_count), 64'(m_led));
    check({name, "_hold"}, {pix_bright, pix_blue, pix_green, pix_red}, 64'(m_last[28:0]));
    bits.delete();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    add(32'h0); add(32'hE510_2030); add(32'hFFFF_FFFF);
    run("basic", 1);
    check("basic_fields", {pix_bright, pix_blue, pix_green, pix_red, led_count}, {5'd5, 24'h102030, 3'd1});
    add(32'h0); repeat (3) add(rnd_pix());
    run("idle_done", 1);
    check("idle_led3", 64'(led_count), 64'd3);
    add(32'h0); add(32'h40FF_FFFF);
    run("bad_hdr", 1);
    add(32'h0); add($urandom, 17);
    run("short", 1);
    check("short_led3", 64'(led_count), 64'd3);
    add(32'h0);
    run("empty", 1);
    add(32'h0, 31); add(32'h1, 1); add(32'h0); add(32'hFFFF_FFFF);
    run("hunt", 1);
    add(32'h0); add(rnd_pix()); add(32'h0); add(rnd_pix()); add(rnd_pix()); add(32'hFFFF_FFFF);
    run("restart", 1);
    add(32'h0); repeat (8) add(rnd_pix());
    run("overflow", 1);
    add(32'h0); add(rnd_pix()); add(rnd_pix());
    run("pre_rst", 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_led = '0;
    m_last = '0;
    add(32'h0); add(rnd_pix()); add(32'hFFFF_FFFF);
    run("post_rst", 1);
    check("post_rst_led1", 64'(led_count), 64'd1);
    for (int f = 0; f < 6; f++) begin
      add($urandom, $urandom_range(0, 20));
      add(32'h0);
      repeat ($urandom_range(0, 4)) add($urandom_range(0, 5) == 0 ? 32'($urandom) : rnd_pix());
      if ($urandom_range(0, 1) == 1) add(32'hFFFF_FFFF);
      run("rand", 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #990_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/dostring_rx.md
DOSTRING_RX -- requirements
Module: dostring_rx

Interface
REQ-001 Parameter IDX_W, default 10: width of the LED index and count outputs.
REQ-002 Parameter IDLE_TIMEOUT, default 4096: dostring_clk cycles with no sck rising edge before the receiver abandons the frame.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on sck and mosi.
REQ-004 dostring_clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 my_reset  in  1  reset, synchronous and active-high.
REQ-006 sck  in  1  serial clock, asynchronous to dostring_clk.
REQ-007 mosi  in  1  serial data, asynchronous to dostring_clk.
REQ-008 pix_valid  out  1  one-cycle strobe: pixel fields are valid.
REQ-009 pix_bright  out  5  global-brightness field of the received LED word.
REQ-010 pix_blue, pix_green, pix_red  out  8 each  colour bytes.
REQ-011 pix_index  out  IDX_W  position of the pixel within the frame, 0-based.
REQ-012 frame_start  out  1  one-cycle strobe: start frame detected.
REQ-013 frame_done  out  1  one-cycle strobe: frame completed.
REQ-014 frame_err  out  1  one-cycle strobe: malformed frame aborted.
REQ-015 led_count  out  IDX_W  number of pixels in the last completed frame.

Function
REQ-016 sck and mosi shall pass through SYNC_STAGES flops, plus one extra sck flop for edge detection.
REQ-017 An sck rising edge shall be detected in the cycle where synced sck=1 and the delayed copy=0.
REQ-018 Synced mosi shall be sampled on each detected edge and shifted MSB-first into a 32-bit word register.
REQ-019 States:
  - HUNT: count consecutive 0 bits; any 1 bit clears the run. At 32, pulse frame_start, clear pix_index and the bit counter, go to PIXEL.
  - PIXEL: collect 32 bits, then classify the word (REQ-020 to REQ-023).
REQ-020 Word 0x00000000 is a repeated start frame: pulse frame_start, clear pix_index, stay in PIXEL.
REQ-021 Word 0xFFFFFFFF is the end frame: pulse frame_done, load led_count with pix_index count, go to HUNT.
REQ-022 Word with bits[31:29]==3'b111 (other than the end frame) is a pixel:
  - Fields: bright=[28:24], blue=[23:16], green=[15:8], red=[7:0].
  - Pulse pix_valid one cycle after the 32nd edge is detected, with pix_index equal to the pre-increment count; then increment.
REQ-023 Any other header shall pulse frame_err and go to HUNT; led_count is unchanged.
REQ-024 A pixel arriving when the count equals 2^IDX_W-1 shall pulse frame_err, emit no pix_valid, and go to HUNT.
REQ-025 In PIXEL, IDLE_TIMEOUT cycles without an edge shall cause:
  - bit counter 0 and count > 0: frame_done, led_count loaded.
  - otherwise: frame_err.
  - In either case, go to HUNT.
REQ-026 The timeout counter shall clear on every detected edge and on entry to PIXEL.
REQ-027 Pixel field outputs shall hold their values until the next pix_valid.
REQ-028 At most one of frame_start, frame_done, frame_err and pix_valid shall be high in any cycle.
REQ-029 Worst-case latency from the sck pin edge to the strobe shall be SYNC_STAGES+2 cycles.
REQ-030 Correct operation shall be guaranteed only when the sck high time and low time are each at least SYNC_STAGES+1 dostring_clk periods.

Reset
REQ-031 While my_reset is high:
  - state = HUNT; all counters, the word register and the synchronizer flops are cleared.
  - All outputs are 0, including led_count.
REQ-032 my_reset asserted mid-frame shall discard the partial frame with no strobe emitted.
REQ-033 my_reset shall take priority over any simultaneous edge or timeout.

Structure
REQ-034 Shared package dostring_pkg shall hold:
  - START_WORD (0x00000000), END_WORD (0xFFFFFFFF), PIX_HDR (3'b111).
  - The state enum {HUNT, PIXEL}.
  - It shall be shared with the transmitter, dostring_wave.
REQ-035 Synchronization and edge detection shall be one sub-module, dostring_sync.
REQ-036 Framing, counters and outputs shall reside in dostring_rx.

Verification
REQ-037 32 zeros, then 0xE5102030, then 0xFFFFFFFF -> the bench shall see:
  - frame_start once.
  - pix_valid once, with bright=5, blue=0x10, green=0x20, red=0x30, index=0.
  - frame_done, with led_count=1.
REQ-038 Start frame, 3 pixels, no end frame, sck idle for 4096 cycles -> frame_done with led_count=3.
REQ-039 Start frame, then word 0x40FFFFFF -> frame_err and no pix_valid.
REQ-040 Start frame, then 17 bits, then idle -> frame_err after timeout; led_count keeps its prior value.
REQ-041 31 zeros, then a 1, then 32 zeros -> exactly one frame_start, after the final zero.
REQ-042 my_reset asserted after 2 pixels, then a full 1-pixel frame -> no strobes during reset, then led_count=1.
